// File: rtl/bdd_pkg.sv
// bdd_pkg: shared types and constants for the BDD accelerator datapath.
//   state_t        : node_eval FSM state encoding
//   P_W_DEF etc.   : default widths for the node evaluator
//   ACC_MAX_DEF /
//   ACC_MIN_DEF    : signed max/min of the default accumulator width
package bdd_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_CMP   = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    localparam int P_W_DEF   = 32;
    localparam int ACC_W_DEF = 40;
    localparam int CNT_W_DEF = 4;

    localparam logic [ACC_W_DEF-1:0] ACC_MAX_DEF = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam logic [ACC_W_DEF-1:0] ACC_MIN_DEF = {1'b1, {(ACC_W_DEF-1){1'b0}}};

endpackage

// File: rtl/node_eval_acc.sv
// node_eval_acc: combinational accumulate step.
//   acc  in  ACC_W  current signed accumulator
//   p    in  P_W    signed product to add (sign-extended to ACC_W)
//   sum  out ACC_W  next accumulator value
//   ovf  out 1      this add left the signed ACC_W range
// Optional feature: NODE_EVAL_SAT_EN -> sum saturates to max/min on overflow;
// otherwise sum wraps modulo 2^ACC_W.
module node_eval_acc #(
    parameter int P_W   = 32,
    parameter int ACC_W = 40
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [P_W-1:0]   p,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W-1:0] p_ext;
    logic [ACC_W-1:0] raw;

    // Replicate the sign bit at least once so the expression stays legal
    // when ACC_W == P_W.
    assign p_ext = {{(ACC_W-P_W+1){p[P_W-1]}}, p[P_W-2:0]};
    assign raw   = acc + p_ext;

    // Signed overflow: operands agree in sign but the result does not.
    assign ovf = (acc[ACC_W-1] == p_ext[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]);

`ifdef NODE_EVAL_SAT_EN
    assign sum = ovf ? (acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : raw;
`else
    assign sum = raw;
`endif

endmodule

// File: rtl/node_eval.sv
// node_eval: accumulates num_terms signed MAC products for one BDD decision
// node and compares the sum against a signed threshold.
//   clk, rst     : clock, synchronous active-high reset
//   start        : begin evaluation (IDLE only); samples num_terms, threshold
//   p_in/p_valid : product stream from mac1, consumed only in ACCUM
//   ce           : mac1 clock-enable, high only in ACCUM
//   busy         : high whenever not IDLE
//   res_valid/res_ready : result handshake
//   branch       : acc >= threshold (signed), acc_out : final sum
//   ovf          : sticky overflow of this evaluation
//   dbg_state    : current FSM state for observation
// Handshake: the result transfers on a cycle where res_valid && res_ready;
// branch/acc_out/ovf stay stable while res_valid is high and res_ready low.
// Optional feature: NODE_EVAL_SAT_EN (saturating accumulator, see node_eval_acc).
module node_eval
    import bdd_pkg::*;
#(
    parameter int P_W   = P_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_terms,
    input  logic [ACC_W-1:0] threshold,
    input  logic [P_W-1:0]   p_in,
    input  logic             p_valid,
    output logic             ce,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             branch,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf,
    output state_t           dbg_state
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t           state, state_nx;
    logic [CNT_W-1:0] n_terms, cnt, cnt_inc;
    logic [ACC_W-1:0] thr, acc, sum;
    logic             add_ovf;

    assign cnt_inc   = cnt + CNT_ONE;
    assign dbg_state = state;

    node_eval_acc #(.P_W(P_W), .ACC_W(ACC_W)) u_acc (
        .acc (acc),
        .p   (p_in),
        .sum (sum),
        .ovf (add_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = (num_terms == '0) ? S_CMP : S_ACCUM;
            S_ACCUM: if (p_valid && (cnt_inc == n_terms)) state_nx = S_CMP;
            S_CMP:   state_nx = S_OUT;
            S_OUT:   if (res_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // with the state register without a decode path after the flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            ce        <= 1'b0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            branch    <= 1'b0;
            acc_out   <= '0;
            ovf       <= 1'b0;
            n_terms   <= '0;
            cnt       <= '0;
            thr       <= '0;
            acc       <= '0;
        end else begin
            ce        <= (state_nx == S_ACCUM);
            busy      <= (state_nx != S_IDLE);
            res_valid <= (state_nx == S_OUT);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_terms <= num_terms;
                        thr     <= threshold;
                        acc     <= '0;
                        cnt     <= '0;
                        ovf     <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (p_valid) begin
                        acc <= sum;
                        cnt <= cnt_inc;
                        if (add_ovf) ovf <= 1'b1;
                    end
                end
                S_CMP: begin
                    branch  <= ($signed(acc) >= $signed(thr));
                    acc_out <= acc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_node_eval.sv
// tb_node_eval: table vectors, randomized evaluations checked against an
// arithmetic reference model, plus hand sequences for reset abort and a
// 32-bit accumulator overflow case on a second instance.
module tb_node_eval;
    import bdd_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main instance (default widths)
    logic        start = 0, p_valid = 0, res_ready = 0;
    logic [3:0]  num_terms = 0;
    logic [39:0] threshold = 0;
    logic [31:0] p_in = 0;
    logic        ce, busy, res_valid, branch, ovf;
    logic [39:0] acc_out;
    state_t      dbg_state;

    node_eval dut (
        .clk(clk), .rst(rst), .start(start), .num_terms(num_terms),
        .threshold(threshold), .p_in(p_in), .p_valid(p_valid), .ce(ce),
        .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .branch(branch), .acc_out(acc_out), .ovf(ovf), .dbg_state(dbg_state)
    );

    // 32-bit accumulator instance for overflow
    logic        o_start = 0, o_p_valid = 0, o_res_ready = 0;
    logic [3:0]  o_num_terms = 0;
    logic [31:0] o_threshold = 0, o_p_in = 0;
    logic        o_ce, o_busy, o_res_valid, o_branch, o_ovf;
    logic [31:0] o_acc_out;
    state_t      o_dbg_state;

    node_eval #(.P_W(32), .ACC_W(32), .CNT_W(4)) dut_o (
        .clk(clk), .rst(rst), .start(o_start), .num_terms(o_num_terms),
        .threshold(o_threshold), .p_in(o_p_in), .p_valid(o_p_valid), .ce(o_ce),
        .busy(o_busy), .res_valid(o_res_valid), .res_ready(o_res_ready),
        .branch(o_branch), .acc_out(o_acc_out), .ovf(o_ovf), .dbg_state(o_dbg_state)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int prods[16];

    typedef struct {
        int     n;
        longint thr;
        int     p0, p1, p2;
        longint exp_acc;
        bit     exp_br;
    } vec_t;
    vec_t tbl[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: exact integer sum, range-checked after every add.
    task automatic model(input int n, input int w, output longint acc, output bit ov);
        longint mx, mn, md;
        mx = (64'sd1 <<< (w-1)) - 1;
        mn = -(64'sd1 <<< (w-1));
        md = 64'sd1 <<< w;
        acc = 0;
        ov  = 0;
        for (int i = 0; i < n; i++) begin
            acc = acc + longint'(prods[i]);
            if (acc > mx) begin
                ov = 1;
`ifdef NODE_EVAL_SAT_EN
                acc = mx;
`else
                acc = acc - md;
`endif
            end else if (acc < mn) begin
                ov = 1;
`ifdef NODE_EVAL_SAT_EN
                acc = mn;
`else
                acc = acc + md;
`endif
            end
        end
    endtask

    task automatic run_eval(input int n, input longint thr, input int gap_max,
                            input int rdy_delay, output longint got_acc, output bit got_br);
        longint e_acc;
        bit     e_ov;
        longint a0;
        bit     b0;
        model(n, 40, e_acc, e_ov);
        start = 1; num_terms = 4'(n); threshold = thr[39:0];
        tick();
        start = 0;
        chk("ce_after_start", longint'(ce), longint'(n != 0));
        chk("busy_after_start", longint'(busy), 1);
        for (int i = 0; i < n; i++) begin
            int g;
            g = $urandom_range(0, gap_max);
            repeat (g) begin
                p_valid = 0; p_in = $urandom;
                tick();
            end
            p_valid = 1; p_in = prods[i];
            tick();
            p_valid = 0;
        end
        // now in the compare cycle
        chk("res_valid_cmp", longint'(res_valid), 0);
        chk("ce_cmp", longint'(ce), 0);
        tick();
        chk("res_valid_out", longint'(res_valid), 1);
        a0 = longint'($signed(acc_out));
        b0 = branch;
        chk("acc_out", a0, e_acc);
        chk("branch", longint'(b0), longint'(e_acc >= thr));
        chk("ovf", longint'(ovf), longint'(e_ov));
        for (int d = 0; d < rdy_delay; d++) begin
            start = 1'($urandom_range(0, 1));
            p_valid = 1; p_in = $urandom;
            tick();
            chk("hold_valid", longint'(res_valid), 1);
            chk("hold_acc", longint'($signed(acc_out)), e_acc);
            chk("hold_branch", longint'(branch), longint'(b0));
        end
        start = 0; p_valid = 0; res_ready = 1;
        tick();
        res_ready = 0;
        chk("res_valid_after_ack", longint'(res_valid), 0);
        chk("busy_after_ack", longint'(busy), 0);
        got_acc = a0;
        got_br  = b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        longint ga, r;
        bit     gb;
        longint e_acc;
        bit     e_ov;

        tbl[0] = '{n:3, thr:50,  p0:10,   p1:20, p2:30, exp_acc:60,  exp_br:1};
        tbl[1] = '{n:3, thr:61,  p0:10,   p1:20, p2:30, exp_acc:60,  exp_br:0};
        tbl[2] = '{n:3, thr:60,  p0:10,   p1:20, p2:30, exp_acc:60,  exp_br:1};
        tbl[3] = '{n:2, thr:-70, p0:-100, p1:30, p2:0,  exp_acc:-70, exp_br:1};
        tbl[4] = '{n:0, thr:0,   p0:0,    p1:0,  p2:0,  exp_acc:0,   exp_br:1};

        // reset state
        tick(); tick();
        chk("rst_ce", longint'(ce), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_res_valid", longint'(res_valid), 0);
        chk("rst_branch", longint'(branch), 0);
        chk("rst_acc_out", longint'(acc_out), 0);
        chk("rst_ovf", longint'(ovf), 0);
        chk("rst_state", longint'(dbg_state), longint'(S_IDLE));
        rst = 0;
        tick();

        // table vectors
        for (int i = 0; i < 5; i++) begin
            prods[0] = tbl[i].p0; prods[1] = tbl[i].p1; prods[2] = tbl[i].p2;
            run_eval(tbl[i].n, tbl[i].thr, (i == 3) ? 3 : 0, (i == 4) ? 5 : 1, ga, gb);
            chk("tbl_acc", ga, tbl[i].exp_acc);
            chk("tbl_branch", longint'(gb), longint'(tbl[i].exp_br));
        end

        // ready held back-to-back: res_ready high as res_valid rises
        prods[0] = 7;
        start = 1; num_terms = 1; threshold = 40'd7;
        tick();
        start = 0; p_valid = 1; p_in = 7;
        tick();
        p_valid = 0; res_ready = 1;
        tick();
        chk("b2b_valid", longint'(res_valid), 1);
        tick();
        res_ready = 0;
        chk("b2b_valid_low", longint'(res_valid), 0);
        chk("b2b_idle", longint'(busy), 0);

        // reset mid-evaluation
        start = 1; num_terms = 3; threshold = 0;
        tick();
        start = 0; p_valid = 1; p_in = 10;
        tick();
        p_valid = 0; rst = 1;
        tick();
        chk("abort_busy", longint'(busy), 0);
        chk("abort_ce", longint'(ce), 0);
        chk("abort_res_valid", longint'(res_valid), 0);
        chk("abort_acc_out", longint'(acc_out), 0);
        rst = 0;
        tick();
        prods[0] = 10; prods[1] = 20; prods[2] = 30;
        run_eval(3, 50, 1, 0, ga, gb);
        chk("fresh_acc", ga, 60);

        // randomized evaluations
        for (int t = 0; t < 30; t++) begin
            int n;
            n = $urandom_range(0, 15);
            for (int j = 0; j < n; j++) prods[j] = int'($urandom);
            model(n, 40, e_acc, e_ov);
            if ($urandom_range(0, 1) == 1) begin
                r = e_acc + longint'($urandom_range(0, 2)) - 1;
            end else begin
                r = {$urandom, $urandom};
                r = (r <<< 24) >>> 24;
            end
            run_eval(n, r, 2, $urandom_range(0, 3), ga, gb);
        end

        // 32-bit accumulator overflow
        o_start = 1; o_num_terms = 2; o_threshold = 0;
        tick();
        o_start = 0; o_p_valid = 1; o_p_in = 32'h7FFF_FFFF;
        tick();
        o_p_in = 32'h1;
        tick();
        o_p_valid = 0;
        tick();
        chk("o_res_valid", longint'(o_res_valid), 1);
        chk("o_ovf", longint'(o_ovf), 1);
`ifdef NODE_EVAL_SAT_EN
        chk("o_acc_out", longint'(o_acc_out), 64'h7FFF_FFFF);
        chk("o_branch", longint'(o_branch), 1);
`else
        chk("o_acc_out", longint'(o_acc_out), 64'h8000_0000);
        chk("o_branch", longint'(o_branch), 0);
`endif
        o_res_ready = 1;
        tick();
        o_res_ready = 0;
        chk("o_busy_after_ack", longint'(o_busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
